// File: rtl/bit_remap_pkg.sv
// Shared types for the programmable bit remapper: op codes and remap table entry.
package bit_remap_pkg;

  // Widest source index a table entry can hold; the top zero-extends cfg_src into it.
  localparam int SRC_MAX_W = 8;

  typedef enum logic [1:0] {
    OP_CONST0 = 2'b00,
    OP_CONST1 = 2'b01,
    OP_PASS   = 2'b10,
    OP_INV    = 2'b11
  } remap_op_e;

  typedef struct packed {
    remap_op_e              op;
    logic [SRC_MAX_W-1:0]   src;
  } remap_entry_t;

  localparam remap_entry_t ENTRY_RST = '{op: OP_CONST0, src: '0};

endpackage

// File: rtl/bit_remap_cell.sv
// One output bit of the remapper: constant, pass or invert of a selected input bit.
module bit_remap_cell
  import bit_remap_pkg::*;
#(
  parameter int IN_W = 15
) (
  input  remap_entry_t    entry,
  input  logic [IN_W-1:0] in_data,
  output logic            out_bit
);

  logic src_bit;

  always_comb begin
    // Sources beyond the input word read as 0.
    src_bit = 1'b0;
    for (int k = 0; k < IN_W; k++) begin
      if (entry.src == SRC_MAX_W'(k)) src_bit = in_data[k];
    end
    out_bit = 1'b0;
    case (entry.op)
      OP_CONST0: out_bit = 1'b0;
      OP_CONST1: out_bit = 1'b1;
      OP_PASS:   out_bit = src_bit;
      OP_INV:    out_bit = ~src_bit;
      default:   out_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_remap_pipe.sv
// Programmable bit remapper behind a single valid/ready register stage.
// Define REMAP_PARITY_EN to add a registered out_parity port.
module bit_remap_pipe
  import bit_remap_pkg::*;
#(
  parameter  int IN_W   = 15,
  parameter  int OUT_W  = 30,
  localparam int SRC_W  = $clog2(IN_W),
  localparam int ADDR_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [1:0]        cfg_op,
  input  logic [SRC_W-1:0]  cfg_src,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
`ifdef REMAP_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  remap_entry_t     table_q [OUT_W];
  remap_entry_t     table_d [OUT_W];
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic [OUT_W-1:0] remap_word;
  logic             accept;

  // Cells read the registered table, so a write in the accept cycle only affects later words.
  for (genvar i = 0; i < OUT_W; i++) begin : g_cell
    bit_remap_cell #(.IN_W(IN_W)) u_cell (
      .entry   (table_q[i]),
      .in_data (in_data),
      .out_bit (remap_word[i])
    );
  end

  always_comb begin
    table_d = table_q;
    for (int k = 0; k < OUT_W; k++) begin
      if (cfg_we && (cfg_addr == ADDR_W'(k))) begin
        table_d[k] = '{op: remap_op_e'(cfg_op), src: SRC_MAX_W'(cfg_src)};
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = remap_word;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < OUT_W; k++) table_q[k] <= ENTRY_RST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      table_q     <= table_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef REMAP_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) parity_d = ^remap_word;
  end

  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_bit_remap_pipe.sv
// Scoreboard bench for bit_remap_pipe: randomized traffic and config against a table model.
module tb_bit_remap_pipe;

  localparam int IN_W   = 15;
  localparam int OUT_W  = 30;
  localparam int SRC_W  = 4;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [1:0]        cfg_op;
  logic [SRC_W-1:0]  cfg_src;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
`ifdef REMAP_PARITY_EN
  logic              out_parity;
`endif

  bit_remap_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_op    (cfg_op),
    .cfg_src   (cfg_src),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef REMAP_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   m_op  [OUT_W];
  int   m_src [OUT_W];
  bit   occ;
  int   cyc;
  int   n_tests;
  int   n_fail;

  // Reference: each output bit follows its table entry; sources past the input word read 0.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] r;
    logic             s;
    for (int i = 0; i < OUT_W; i++) begin
      s = (m_src[i] < IN_W) ? d[m_src[i]] : 1'b0;
      case (m_op[i])
        0:       r[i] = 1'b0;
        1:       r[i] = 1'b1;
        2:       r[i] = s;
        default: r[i] = ~s;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < OUT_W; i++) begin
      m_op[i]  = 0;
      m_src[i] = 0;
    end
    occ = 1'b0;
    sb.delete();
  endtask

  task automatic drive(input bit iv, input logic [IN_W-1:0] d, input bit ordy,
                       input bit we, input int addr, input int op, input int src,
                       input bit lit_en, input logic [OUT_W-1:0] lit);
    exp_t e;
    bit   exp_rdy;
    bit   acc;
    @(negedge clk);
    cyc++;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    cfg_we    = we;
    cfg_addr  = ADDR_W'(addr);
    cfg_op    = 2'(op);
    cfg_src   = SRC_W'(src);
    #1;
    exp_rdy = !occ || ordy;
    check("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy;
    if (acc) begin
      e.data = lit_en ? lit : model(d);
      e.cyc  = cyc;
      sb.push_back(e);
    end
    occ = acc ? 1'b1 : (ordy ? 1'b0 : occ);
    if (we && addr < OUT_W) begin
      m_op[addr]  = op;
      m_src[addr] = src;
    end
  endtask

  task automatic send(input logic [IN_W-1:0] d, input bit ordy);
    drive(1'b1, d, ordy, 1'b0, 0, 0, 0, 1'b0, '0);
  endtask

  task automatic send_lit(input logic [IN_W-1:0] d, input logic [OUT_W-1:0] lit);
    drive(1'b1, d, 1'b1, 1'b0, 0, 0, 0, 1'b1, lit);
  endtask

  task automatic cfg(input int addr, input int op, input int src);
    drive(1'b0, IN_W'($urandom), 1'b1, 1'b1, addr, op, src, 1'b0, '0);
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, IN_W'($urandom), ordy, 1'b0, 0, 0, 0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef REMAP_PARITY_EN
    check("rst_parity", out_parity, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: the oldest accepted word must be presented from the cycle after its accept.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb[0];
        check("out_valid", out_valid, 1);
        check("out_data", out_data, e.data);
`ifdef REMAP_PARITY_EN
        check("out_parity", out_parity, ^e.data);
`endif
        if (out_valid && out_ready) void'(sb.pop_front());
      end else begin
        check("idle_valid", out_valid, 0);
      end
    end
  end

  logic [11:0] legacy_lo;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_op    = '0;
    cfg_src   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    do_reset();
    send_lit(15'h7FFF, 30'h0);

    legacy_lo = 12'b011011101000;
    for (int i = 0; i < 12; i++) cfg(i, legacy_lo[i] ? 1 : 0, 0);
    cfg(12, 2, 0);
    cfg(13, 2, 1);
    cfg(14, 0, 0);
    cfg(15, 1, 0);
    for (int i = 16; i < 19; i++) cfg(i, 2, i - 12);
    cfg(19, 0, 0);
    cfg(20, 1, 0);
    cfg(21, 2, 9);
    cfg(22, 3, 10);
    cfg(23, 0, 0);
    cfg(24, 1, 0);
    cfg(25, 1, 0);
    cfg(26, 0, 0);
    for (int i = 27; i < 30; i++) cfg(i, 2, i - 15);
    send_lit(15'h7FFF, 30'h3B37B6E8);
    send_lit(15'h0000, 30'h035086E8);
    idle(1'b1);

    // Stall with a held word, then release together with a new word.
    send(IN_W'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) send(IN_W'($urandom), 1'b0);
    send(IN_W'($urandom), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Config write in the same cycle as an accept, then out-of-range addresses.
    send(15'h1234, 1'b1);
    drive(1'b1, 15'h5555, 1'b1, 1'b1, 0, 1, 0, 1'b0, '0);
    send(15'h2AAA, 1'b1);
    cfg(31, 1, 3);
    cfg(30, 3, 2);
    send(15'h0F0F, 1'b1);

    cfg(5, 2, 15);
    cfg(6, 3, 15);
    for (int i = 0; i < 4; i++) send(IN_W'($urandom), 1'b1);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, IN_W'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 31), $urandom_range(0, 3),
            $urandom_range(0, 15), 1'b0, '0);
    end

    // Reset with a word held under stall drops it and clears the table.
    send(15'h7FFF, 1'b0);
    idle(1'b0);
    do_reset();
    send(15'h7FFF, 1'b1);
    send(IN_W'($urandom), 1'b1);

    for (int i = 0; i < 50 && sb.size() > 0; i++) idle(1'b1);
    idle(1'b1);
    check("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
